// File: rtl/disp_pkg.sv
// Shared types and constants for the BCD-to-7-segment latch/decoder/driver.
// Segment vectors are ordered abcdefg, MSB = a, with 1 meaning the segment is lit.
package disp_pkg;

  typedef logic [6:0] seg7;

  localparam seg7 SEG_ALL_ON  = 7'b1111111;
  localparam seg7 SEG_ALL_OFF = 7'b0000000;

  // Indexed by BCD code; 6 and 9 carry tails, codes 10..15 blank.
  localparam logic [15:0][6:0] BCD_SEG_TABLE = {
    7'b0000000,  // 15
    7'b0000000,  // 14
    7'b0000000,  // 13
    7'b0000000,  // 12
    7'b0000000,  // 11
    7'b0000000,  // 10
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/disp_decoder_bcd_to_seg7.sv
// Purely combinational BCD code to abcdefg segment decode; invalid codes blank.
module bcd_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] code,
  output seg7        seg
);

  assign seg = BCD_SEG_TABLE[code];

endmodule

// File: rtl/disp_decoder.sv
// 4511-style latch/decoder/driver: transparent BCD latch, lamp-test/blank
// overrides, registered segment output with optional common-anode polarity.
module disp_decoder
  import disp_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LE,
  input  logic       BL,
  input  logic       LT,
  input  logic [3:0] D,
  output logic [6:0] L
);

  logic [3:0] code_p0;
  logic [3:0] eff_code;
  seg7        dec_seg;
  seg7        seg_p1;

  // Lamp test wins over blanking, which wins over the decoded digit.
  function automatic seg7 resolve_overrides(input logic lt_n, input logic bl_n,
                                            input seg7 dec);
    seg7 res;
    res = dec;
    if (!lt_n)
      res = SEG_ALL_ON;
    else if (!bl_n)
      res = SEG_ALL_OFF;
    return res;
  endfunction

  function automatic seg7 apply_polarity(input seg7 seg);
    return SEG_ACTIVE_LOW ? ~seg : seg;
  endfunction

  // Stage p0: code latch, transparent while LE is low.
  always_ff @(posedge clk) begin
    if (rst)
      code_p0 <= 4'd0;
    else if (!LE)
      code_p0 <= D;
  end

  assign eff_code = LE ? code_p0 : D;

  bcd_to_seg7 u_dec (
    .code (eff_code),
    .seg  (dec_seg)
  );

  // Stage p1: registered segment drive after override priority.
  always_ff @(posedge clk) begin
    if (rst)
      seg_p1 <= SEG_ALL_OFF;
    else
      seg_p1 <= resolve_overrides(LT, BL, dec_seg);
  end

  assign L = apply_polarity(seg_p1);

endmodule

// File: tb/tb_disp_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed segment patterns, a monitor
// pops one per clock and checks both an active-high and an active-low instance.
module tb_disp_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       le;
  logic       bl;
  logic       lt;
  logic [3:0] d;
  logic [6:0] l_hi;
  logic [6:0] l_lo;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  disp_decoder #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk (clk), .rst (rst), .LE (le), .BL (bl), .LT (lt), .D (d), .L (l_hi)
  );

  disp_decoder #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clk (clk), .rst (rst), .LE (le), .BL (bl), .LT (lt), .D (d), .L (l_lo)
  );

  // Monitor: each result is visible just after the edge that sampled its inputs.
  logic [6:0] mon_exp;
  string      mon_name;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      checks++;
      if (l_hi !== mon_exp) begin
        errors++;
        $display("FAIL %s (active-high): L=%b expected %b", mon_name, l_hi, mon_exp);
      end
      checks++;
      if (l_lo !== ~mon_exp) begin
        errors++;
        $display("FAIL %s (active-low): L=%b expected %b", mon_name, l_lo, ~mon_exp);
      end
    end
  end

  task automatic step(input logic r, input logic le_i, input logic bl_i,
                      input logic lt_i, input logic [3:0] d_i,
                      input logic [6:0] e, input string n);
    @(negedge clk);
    rst = r;
    le  = le_i;
    bl  = bl_i;
    lt  = lt_i;
    d   = d_i;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  logic [6:0] digit_tbl [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  initial begin
    rst = 1'b1; le = 1'b0; bl = 1'b1; lt = 1'b1; d = 4'd8;

    // Reset, then release: D=8 shown on the next clock.
    step(1, 0, 1, 1, 4'd8, 7'b0000000, "reset0");
    step(1, 0, 1, 1, 4'd8, 7'b0000000, "reset1");
    step(0, 0, 1, 1, 4'd8, 7'b1111111, "post_reset_8");

    // Lamp test, and lamp test beating blanking.
    step(0, 1, 1, 0, 4'd0, 7'b1111111, "lamp_test");
    step(0, 1, 0, 0, 4'd0, 7'b1111111, "lt_beats_bl");

    step(0, 0, 1, 1, 4'd4, 7'b0110011, "digit4");
    step(0, 0, 1, 1, 4'd9, 7'b1111011, "digit9");

    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 1, 4'(i), digit_tbl[i], $sformatf("sweep_%0d", i));

    for (int i = 10; i < 16; i++)
      step(0, 0, 1, 1, 4'(i), 7'b0000000, $sformatf("invalid_%0d", i));

    // Latch hold, including LE rising together with a D change.
    step(0, 0, 1, 1, 4'd4, 7'b0110011, "latch_load4");
    step(0, 1, 1, 1, 4'd9, 7'b0110011, "latch_hold4");
    step(0, 1, 1, 0, 4'd9, 7'b1111111, "latch_lt_pulse");
    step(0, 1, 1, 1, 4'd9, 7'b0110011, "latch_after_lt");
    step(0, 0, 1, 1, 4'd9, 7'b1111011, "latch_release9");

    // Blanking while holding, then unblank shows held digit.
    step(0, 1, 0, 1, 4'd0, 7'b0000000, "blank_hold");
    step(0, 1, 1, 1, 4'd0, 7'b1111011, "unblank_held9");

    // An invalid code can be latched and stays blank.
    step(0, 0, 1, 1, 4'd12, 7'b0000000, "latch_invalid");
    step(0, 1, 1, 1, 4'd3, 7'b0000000, "hold_invalid");

    // Reset mid-run clears the latch to 0.
    step(1, 1, 1, 1, 4'd5, 7'b0000000, "reset_mid");
    step(0, 1, 1, 1, 4'd5, 7'b1111110, "held_after_reset");

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      #2;
      if (exp_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_decoder.md
Name: disp_decoder

Overview:
Clocked model of a 74HC4511-style BCD-to-7-segment latch/decoder/driver.
- A 4-bit BCD code is captured into an internal latch register under latch-enable control.
- The latched code is decoded to seven active-high segment drives.
- Lamp-test and blanking overrides are applied to the decoded segments.
- Sits between a BCD counter/datapath and a common-cathode 7-segment display.

Parameters:
SEG_ACTIVE_LOW, 0, when 1 the final L output is bitwise inverted (common-anode panels); all behaviour below is stated for 0.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous reset, active-high
LE   input  1  latch enable, active-high hold: 0 = transparent (capture D every clock), 1 = hold stored code
BL   input  1  blanking, active-low: 0 forces all segments off (unless LT=0)
LT   input  1  lamp test, active-low: 0 forces all segments on; highest priority after rst
D    input  4  BCD code in, D[3] = MSB
L    output 7  segment drives, L[6]=a, L[5]=b, L[4]=c, L[3]=d, L[2]=e, L[1]=f, L[0]=g; 1 = segment lit

Behaviour:
- Reset (sampled at rising clk while rst=1): latch register <= 4'd0; L <= 7'b0000000 (blank). Reset overrides all inputs.
- Latch register, each rising clk with rst=0:
  - LE=0: latch <= D.
  - LE=1: latch holds its value.
  - LT and BL never affect latch contents.
- Effective code: D when LE=0, otherwise the latch register (transparent-latch behaviour).
- Output register, each rising clk with rst=0, in this priority:
  1. LT=0: L <= 7'b1111111, regardless of BL, LE and D.
  2. Else BL=0: L <= 7'b0000000.
  3. Else: L <= decode(effective code).
- Latency: any input change appears on L exactly one clock after it is sampled. L is a registered output with no combinational input-to-output path.
- Decode table (abcdefg), 6 and 9 drawn with tails per the 4511 font:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Codes 10..15 are invalid and decode to 0000000 (blank). An invalid code may still be latched.
- Simultaneous LE rise with a D change: the edge samples LE=1, so the old latched value is kept.
- Lamp test while LE=1 does not disturb the stored code. Releasing LT shows the held digit on the next clock.
- SEG_ACTIVE_LOW=1: L is inverted after priority resolution, so the reset value becomes 7'b1111111.

Decomposition:
- Shared package disp_pkg:
  - seg7 typedef (7-bit, abcdefg ordering)
  - SEG_ALL_ON / SEG_ALL_OFF constants
  - the 16-entry BCD decode constant table
- One natural sub-module: bcd_to_seg7, purely combinational: 4-bit code in, 7-bit segments out, invalid codes blank.
- disp_decoder holds the latch register, override priority and output register.

Test Plan:
- rst=1 for 2 clocks with D=4'd8, LE=0, BL=1, LT=1 -> L=0000000. Deassert rst -> L=1111111 one clock later.
- LT=0, BL=1, LE=1, D=0 -> L=1111111 one clock later. Then LT=0 with BL=0 -> L stays 1111111 (LT beats BL).
- LE=0, BL=1, LT=1, D=4 -> L=0110011. Then D=9 -> L=1111011. Sweep D=0..9 and check the full decode table.
- LE=0, BL=1, LT=1, D=13 (and 10..15) -> L=0000000.
- Latch check, BL=1, LT=1:
  - LE=0 with D=4, then LE=1 with D=9 -> L stays 0110011.
  - Pulse LT=0 for one clock -> L=1111111, then L returns to 0110011.
  - LE=0 -> L=1111011 on the next clock.
- LE=1, BL=0, LT=1, D=0 -> L=0000000. Raise BL=1 -> L shows the held digit. SEG_ACTIVE_LOW=1 instance -> every expected value bitwise inverted.
